// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage: MEM/WB pipeline register and register-file write-port driver.
//
// Captures the instruction sitting in EX/MEM and produces the register-file
// write (enable, address, data) one cycle later. Load data is aligned and
// sign/zero-extended from the data-memory read word. While a load waits for
// its memory response the stage stalls IF..MEM and writes bubbles. A load
// whose response never arrives is abandoned after TIMEOUT_CYCLES and a sticky
// error flag is raised.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   ex_mem_valid             EX/MEM holds a real instruction
//   ex_mem_RegWrite          instruction writes rd
//   ex_mem_rd                destination register
//   ex_mem_wb_sel            00 ALU, 01 load, 10 PC+4, 11 ALU
//   ex_mem_funct3            load type (lb/lh/lw/lbu/lhu)
//   ex_mem_addr_lo           load byte address [1:0]
//   ex_mem_alu_result        ALU result
//   ex_mem_pc_plus4          link value
//   flush                    squash the instruction in MEM
//   mem_rvalid, mem_rdata    data-memory read response
//   MEM_WB_RegWrite          register-file write enable (registered)
//   MEM_WB_rd                register-file write address (registered)
//   rd_data                  register-file write data (registered)
//   mem_stall                hold IF..MEM (combinational)
//   load_timeout             sticky load-timeout error (registered)
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid,
  input  logic        ex_mem_RegWrite,
  input  logic [4:0]  ex_mem_rd,
  input  logic [1:0]  ex_mem_wb_sel,
  input  logic [2:0]  ex_mem_funct3,
  input  logic [1:0]  ex_mem_addr_lo,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_pc_plus4,
  input  logic        flush,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        MEM_WB_RegWrite,
  output logic [4:0]  MEM_WB_rd,
  output logic [31:0] rd_data,
  output logic        mem_stall,
  output logic        load_timeout
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              we_q,    we_d;
  logic [4:0]        rd_q,    rd_d;
  logic [31:0]       data_q,  data_d;
  logic              tmo_q,   tmo_d;

  logic              is_load;
  logic              capture;
  logic              timeout_hit;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [31:0]       load_val;
  logic [31:0]       wb_val;

  assign is_load = ex_mem_valid && (ex_mem_wb_sel == 2'b01);

  // ---------------------------------------------------------------------------
  // State register (also holds the wait counter and the registered outputs)
  // ---------------------------------------------------------------------------
  // NOTE: every register, including the output data, is reset so the write
  // port is quiet and deterministic immediately after rst, even mid-load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so all registers update from the
      // same pre-edge values; the comb blocks below use blocking assignments.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    timeout_hit = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (is_load && !mem_rvalid && !flush) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          capture = 1'b1;
        end
      end
      ST_WAIT: begin
        // Upstream holds EX/MEM stable, so the load is still presented here.
        if (flush) begin
          // Flush wins over a response arriving in the same cycle.
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (mem_rvalid) begin
          capture = 1'b1;
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q >= TIMEOUT_CNT) begin
          timeout_hit = 1'b1;
          state_d     = ST_RUN;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load alignment and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    load_byte = mem_rdata[7:0];
    unique case (ex_mem_addr_lo)
      2'd0: load_byte = mem_rdata[7:0];
      2'd1: load_byte = mem_rdata[15:8];
      2'd2: load_byte = mem_rdata[23:16];
      2'd3: load_byte = mem_rdata[31:24];
      default: load_byte = mem_rdata[7:0];
    endcase
  end

  // Halfword accesses ignore addr_lo[0].
  assign load_half = ex_mem_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_val = mem_rdata;
    unique case (ex_mem_funct3)
      3'b000:  load_val = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_val = {{16{load_half[15]}}, load_half};
      3'b100:  load_val = {24'h0, load_byte};
      3'b101:  load_val = {16'h0, load_half};
      default: load_val = mem_rdata;   // lw and undefined encodings
    endcase
  end

  always_comb begin
    wb_val = ex_mem_alu_result;
    unique case (ex_mem_wb_sel)
      2'b01:   wb_val = load_val;
      2'b10:   wb_val = ex_mem_pc_plus4;
      default: wb_val = ex_mem_alu_result;   // 00 and 11
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Stall drops in the timeout cycle so the pipeline can move past the load.
    mem_stall = !rst && !flush && is_load && !mem_rvalid &&
                ((state_q == ST_RUN) || (cnt_q < TIMEOUT_CNT));

    // Bubble by default: no write, address/data keep their last values.
    we_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    tmo_d  = tmo_q | timeout_hit;

    if (capture) begin
      we_d   = ex_mem_valid && ex_mem_RegWrite && (ex_mem_rd != 5'd0) && !flush;
      rd_d   = ex_mem_rd;
      data_d = wb_val;
    end
  end

  assign MEM_WB_RegWrite = we_q;
  assign MEM_WB_rd       = rd_q;
  assign rd_data         = data_q;
  assign load_timeout    = tmo_q;

endmodule
